mem_ctrl: RTL and testbench

//   Memory access controller between the CPU datapath and the synchronous-read RAM.

---
 rtl/mem_ctrl_if.sv | 32 +++
 rtl/mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// CPU-side request/acknowledge bundle for mem_ctrl.
//   cpu_req    request, held high by the CPU until cpu_ack is seen
//   cpu_we     1 = store, 0 = load; valid with cpu_req
//   cpu_addr   word address; MSB selects I/O space
//   cpu_wdata  store data
//   cpu_rdata  load result, holds until the next load completes
//   cpu_ack    one-cycle completion pulse
// Modports: master = CPU datapath, slave = mem_ctrl.
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int CPU_ADDR_WIDTH = 9
);
  logic                      cpu_req;
  logic                      cpu_we;
  logic [CPU_ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]     cpu_wdata;
  logic [DATA_WIDTH-1:0]     cpu_rdata;
  logic                      cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Memory access controller between the CPU datapath and a synchronous-read RAM.
// One load or store at a time over a req/ack handshake; sequences the RAM's
// one-cycle read latency and decodes the upper address half as I/O space.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   cpu                 mem_ctrl_if.slave request bundle
//   busy                high in every state except IDLE
//   ram_read_address    RAM read address (always addr_q)
//   ram_write_address   RAM write address (always addr_q)
//   ram_write           RAM write enable, only in WR for RAM-space addresses
//   ram_din             RAM write data (always wdata_q)
//   ram_dout            RAM read data, valid one cycle after the read address
//   sw                  switch inputs (I/O space)
//   leds                LED register (I/O space)
//
// Configuration macro: MMIO_EN
//   defined   : load 0x140 returns switches, store 0x100 writes leds
//   undefined : I/O loads return 0, I/O stores dropped, leds tied to 0
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int CPU_ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_ctrl_if.slave             cpu,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  output logic [ADDR_WIDTH-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic [7:0]            sw,
  output logic [7:0]            leds
);

  localparam int MSB = CPU_ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR,
    DONE
  } state_t;

  state_t state, next_state;

  logic [CPU_ADDR_WIDTH-1:0] addr_q;
  logic                      we_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [DATA_WIDTH-1:0]     io_rdata;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      ack;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; DONE always returns to IDLE so a held request is
  // only accepted after one idle cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cpu.cpu_req) begin
          next_state = cpu.cpu_we ? WR : RD_ISSUE;
        end
      end
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT:  next_state = DONE;
      WR:       next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode straight from state, so an async reset in WR kills the
  // write enable in the same cycle.
  always_comb begin
    ack       = 1'b0;
    busy      = 1'b1;
    ram_write = 1'b0;
    case (state)
      IDLE: busy      = 1'b0;
      WR:   ram_write = ~addr_q[MSB];
      DONE: ack       = 1'b1;
      default: ;
    endcase
  end

  // Request capture; later changes on the bus are ignored until IDLE again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE && cpu.cpu_req) begin
      addr_q  <= cpu.cpu_addr;
      we_q    <= cpu.cpu_we;
      wdata_q <= cpu.cpu_wdata;
    end
  end

  assign ram_read_address  = addr_q[ADDR_WIDTH-1:0];
  assign ram_write_address = addr_q[ADDR_WIDTH-1:0];
  assign ram_din           = wdata_q;

`ifdef MMIO_EN
  localparam logic [CPU_ADDR_WIDTH-1:0] LED_ADDR = CPU_ADDR_WIDTH'(32'h100);
  localparam logic [CPU_ADDR_WIDTH-1:0] SW_ADDR  = CPU_ADDR_WIDTH'(32'h140);

  always_comb begin
    io_rdata = '0;
    if (addr_q == SW_ADDR) begin
      io_rdata[7:0] = sw;
    end
  end

  // LED register commits at the WR->DONE edge, same as a RAM write would.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= 8'h00;
    end else if (state == WR && addr_q == LED_ADDR) begin
      leds <= wdata_q[7:0];
    end
  end
`else
  logic unused_sw;

  assign io_rdata  = '0;
  assign leds      = 8'h00;
  assign unused_sw = ^sw;
`endif

  assign rd_data = addr_q[MSB] ? io_rdata : ram_dout;

  // Load result register; ram_dout is valid during RD_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (state == RD_WAIT && !we_q) begin
      rdata_q <= rd_data;
    end
  end

  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_ack   = ack;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. A behavioural synchronous RAM sits on the
// RAM port; a separate word-array reference model predicts load data, LED
// state and handshake timing. Expectations follow MMIO_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        busy;
  logic [7:0]  ram_read_address;
  logic [7:0]  ram_write_address;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  sw;
  logic [7:0]  leds;

  mem_ctrl_if #(.DATA_WIDTH(16), .CPU_ADDR_WIDTH(9)) cpu ();

  mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .CPU_ADDR_WIDTH(9)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu               (cpu.slave),
    .busy              (busy),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_write         (ram_write),
    .ram_din           (ram_din),
    .ram_dout          (ram_dout),
    .sw                (sw),
    .leds              (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous-read RAM (environment, not the reference model)
  logic [15:0] ram_mem [0:255];

  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_write_address] <= ram_din;
    ram_dout <= ram_mem[ram_read_address];
  end

  // Reference model state
  logic [15:0] ref_mem [0:255];
  logic [7:0]  ref_leds;

  int checks;
  int errors;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelLoad(input logic [8:0] addr, output logic [15:0] data);
    data = 16'h0000;
    if (!addr[8]) data = ref_mem[addr[7:0]];
`ifdef MMIO_EN
    else if (addr == 9'h140) data = {8'h00, sw};
`endif
  endtask

  task automatic modelStore(input logic [8:0] addr, input logic [15:0] data);
    if (!addr[8]) ref_mem[addr[7:0]] = data;
`ifdef MMIO_EN
    else if (addr == 9'h100) ref_leds = data[7:0];
`endif
  endtask

  // One complete operation from an idle controller, with all timing checks.
  task automatic applyStimulus(input string tag, input logic we, input logic [8:0] addr,
                               input logic [15:0] wdata);
    int          lat;
    int          ack_at;
    int          wr_cnt;
    logic [15:0] exp_rd;
    @(negedge clk);
    cpu.cpu_req   = 1'b1;
    cpu.cpu_we    = we;
    cpu.cpu_addr  = addr;
    cpu.cpu_wdata = wdata;
    lat    = we ? 2 : 3;
    exp_rd = 16'h0000;
    if (we) modelStore(addr, wdata);
    else    modelLoad(addr, exp_rd);
    ack_at = 0;
    wr_cnt = 0;
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      if (ram_write) wr_cnt++;
      if (cpu.cpu_ack && ack_at == 0) ack_at = k;
      if (ack_at != 0) cpu.cpu_req = 1'b0;
      cpu.cpu_we    = 1'($urandom);
      cpu.cpu_addr  = 9'($urandom);
      cpu.cpu_wdata = 16'($urandom);
    end
    cpu.cpu_req = 1'b0;
    checkOutput({tag, "_ack_lat"}, 32'(ack_at), 32'(lat));
    checkOutput({tag, "_wr_cycles"}, 32'(wr_cnt), 32'(we && !addr[8]));
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, "_leds"}, 32'(leds), 32'(ref_leds));
    if (!we) checkOutput({tag, "_rdata"}, 32'(cpu.cpu_rdata), 32'(exp_rd));
  endtask

  logic        we6   [0:7];
  logic [8:0]  addr6 [0:7];
  logic [15:0] data6 [0:7];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 16'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    ref_leds      = 8'h00;
    sw            = 8'h00;
    reset         = 1'b1;
    cpu.cpu_req   = 1'b0;
    cpu.cpu_we    = 1'b0;
    cpu.cpu_addr  = '0;
    cpu.cpu_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle outputs after reset
    @(negedge clk);
    checkOutput("t1_ack", 32'(cpu.cpu_ack), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_ram_write", 32'(ram_write), 32'd0);
    checkOutput("t1_rdata", 32'(cpu.cpu_rdata), 32'd0);
    checkOutput("t1_leds", 32'(leds), 32'd0);

    // 2: store then load back
    applyStimulus("t2_st", 1'b1, 9'h005, 16'h1234);
    applyStimulus("t2_ld", 1'b0, 9'h005, 16'h0000);
    checkOutput("t2_rdata_const", 32'(cpu.cpu_rdata), 32'h1234);

    // 3: I/O-space load that would alias RAM word 5 if the MSB were ignored
    applyStimulus("t3_ld_io", 1'b0, 9'h105, 16'h0000);
    checkOutput("t3_rdata_zero", 32'(cpu.cpu_rdata), 32'd0);
    checkOutput("t3_ram5", 32'(ram_mem[5]), 32'h1234);

    // 4: memory-mapped switches and LEDs
    sw = 8'hA5;
    applyStimulus("t4_ld_sw", 1'b0, 9'h140, 16'h0000);
`ifdef MMIO_EN
    checkOutput("t4_sw_value", 32'(cpu.cpu_rdata), 32'h00A5);
`else
    checkOutput("t4_sw_value", 32'(cpu.cpu_rdata), 32'h0000);
`endif
    applyStimulus("t4_st_led", 1'b1, 9'h100, 16'h00FF);
`ifdef MMIO_EN
    checkOutput("t4_led_value", 32'(leds), 32'hFF);
`else
    checkOutput("t4_led_value", 32'(leds), 32'h00);
`endif

    // 5: reset in the WR cycle aborts the store
    @(negedge clk);
    cpu.cpu_req   = 1'b1;
    cpu.cpu_we    = 1'b1;
    cpu.cpu_addr  = 9'h010;
    cpu.cpu_wdata = 16'hBEEF;
    @(negedge clk);
    checkOutput("t5_wr_before", 32'(ram_write), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5_wr_drop", 32'(ram_write), 32'd0);
    checkOutput("t5_busy_rst", 32'(busy), 32'd0);
    cpu.cpu_req = 1'b0;
    ref_leds    = 8'h00;
    @(negedge clk);
    checkOutput("t5_ack_rst", 32'(cpu.cpu_ack), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_ack_after", 32'(cpu.cpu_ack), 32'd0);
    checkOutput("t5_busy_after", 32'(busy), 32'd0);
    checkOutput("t5_rdata", 32'(cpu.cpu_rdata), 32'd0);
    checkOutput("t5_leds", 32'(leds), 32'd0);
    checkOutput("t5_ram10", 32'(ram_mem[16]), 32'(ref_mem[16]));
    applyStimulus("t5_ld", 1'b0, 9'h010, 16'h0000);

    // 6: request held high continuously, alternating store/load pairs
    for (int i = 0; i < 8; i++) begin
      we6[i]   = (i % 2 == 0);
      addr6[i] = (i % 2 == 0) ? 9'($urandom_range(0, 255)) : addr6[i-1];
      data6[i] = 16'($urandom);
    end
    @(negedge clk);
    cpu.cpu_req   = 1'b1;
    cpu.cpu_we    = we6[0];
    cpu.cpu_addr  = addr6[0];
    cpu.cpu_wdata = data6[0];
    for (int i = 0; i < 8; i++) begin
      int          lat;
      int          ack_at;
      int          ack_cnt;
      int          busy_low;
      logic [15:0] exp_rd;
      lat      = we6[i] ? 2 : 3;
      ack_at   = 0;
      ack_cnt  = 0;
      busy_low = 0;
      exp_rd   = 16'h0000;
      if (we6[i]) modelStore(addr6[i], data6[i]);
      else        modelLoad(addr6[i], exp_rd);
      for (int k = 1; k <= lat + 1; k++) begin
        @(negedge clk);
        if (cpu.cpu_ack) begin
          ack_cnt++;
          if (ack_at == 0) ack_at = k;
        end
        if (!busy) busy_low++;
        if (k == lat) begin
          if (i < 7) begin
            cpu.cpu_we    = we6[i+1];
            cpu.cpu_addr  = addr6[i+1];
            cpu.cpu_wdata = data6[i+1];
          end else begin
            cpu.cpu_req = 1'b0;
          end
        end
      end
      checkOutput($sformatf("t6_op%0d_ack_at", i), 32'(ack_at), 32'(lat));
      checkOutput($sformatf("t6_op%0d_ack_cnt", i), 32'(ack_cnt), 32'd1);
      checkOutput($sformatf("t6_op%0d_busy_low", i), 32'(busy_low), 32'd1);
      if (!we6[i]) checkOutput($sformatf("t6_op%0d_rdata", i), 32'(cpu.cpu_rdata), 32'(exp_rd));
    end
    cpu.cpu_req = 1'b0;

    // 7: randomized mix of RAM and I/O accesses
    for (int i = 0; i < 40; i++) begin
      logic [8:0] a;
      int         sel;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       a = 9'h100;
        1:       a = 9'h140;
        2:       a = {1'b1, 8'($urandom)};
        default: a = 9'($urandom_range(0, 15));
      endcase
      sw = 8'($urandom);
      applyStimulus($sformatf("t7_%0d", i), 1'($urandom), a, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
